sha_state_ctrl: RTL

Sequencer for a Versat SHA state-accumulator unit, whose output is its register value plus its input on every run. The block holds the block count and the delay value, pulses the unit's run once per message block, waits for its done, and counts completed blocks. It reports completion to the host through a memory-mapped control interface. It sits between the Versat control bus and one accumulator datapath instance.

---
 rtl/sha_state_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sha_state_ctrl.sv
// Sequencer for a SHA state-accumulator unit: issues one acc_run per block, waits for acc_done, counts blocks.
// Latency: start write edge -> acc_run next cycle; min 3 cycles/block; registered one-cycle ready per request.
// Backpressure: valid held until the ready pulse; optional watchdog enabled by macro SHA_CTRL_TIMEOUT_EN.
module sha_state_ctrl #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                acc_run,
  input  logic                acc_done,
  output logic [31:0]         acc_delay,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ready;
  logic [DATA_W-1:0]  r_rdata;
  logic [15:0]        r_nblocks;
  logic [31:0]        r_delay;
  logic [15:0]        r_count;
  logic               r_done;
  logic               r_guard;
  logic               w_error;
  logic               w_timeout;
  logic               w_acc_run;
  logic [31:0]        w_rmux;

  // Bus decode: reads are captured when the request is first seen, writes land on the ready edge.
  wire w_req_rd    = valid & ~r_ready & ~(|wstrb);
  wire w_wr        = valid & r_ready & (|wstrb);
  wire w_ctrl_wr   = w_wr & (addr[1:0] == 2'd0);
  wire w_abort     = w_ctrl_wr & wdata[1];
  wire w_start     = w_ctrl_wr & wdata[0] & ~wdata[1];
  wire w_idle      = (r_state == S_IDLE);
  wire w_cfg_wr    = w_wr & w_idle;
  wire [15:0] w_count_inc = r_count + 16'd1;
  // The first WAIT cycle ignores acc_done since it may still be high from the previous run.
  wire w_blk_done  = (r_state == S_WAIT) & ~r_guard & acc_done & ~w_abort;

`ifdef SHA_CTRL_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_error;

  // Watchdog: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  // Error flag: raised by the watchdog, cleared by the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_error <= 1'b0;
    end else if (w_idle && w_start) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign w_error = r_error;
`else
  assign w_error = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and run pulse; abort suppresses acc_run in the cycle it lands.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_run   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (r_nblocks == 16'd0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_run   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_blk_done) begin
          w_state_nxt = (w_count_inc == r_nblocks) ? S_FINISH : S_ISSUE;
        end
`ifdef SHA_CTRL_TIMEOUT_EN
        else if (r_wdog == 32'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Guard flag marks the first WAIT cycle after each issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_guard <= 1'b0;
    end else begin
      r_guard <= (r_state == S_ISSUE);
    end
  end

  // Block counter and sticky done flag; both cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (w_idle && w_start) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_blk_done) begin
        r_count <= w_count_inc;
      end
      if (r_state == S_FINISH) begin
        r_done <= 1'b1;
      end
    end
  end

  // Configuration registers, frozen while a sequence is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nblocks <= '0;
      r_delay   <= '0;
    end else if (w_cfg_wr) begin
      if (addr[1:0] == 2'd1) begin
        r_nblocks <= wdata[15:0];
      end
      if (addr[1:0] == 2'd2) begin
        r_delay <= wdata[31:0];
      end
    end
  end

  // Read mux; CTRL reads as zero.
  always_comb begin
    w_rmux = '0;
    case (addr[1:0])
      2'd1:    w_rmux = {16'd0, r_nblocks};
      2'd2:    w_rmux = r_delay;
      2'd3:    w_rmux = {r_count, 13'd0, w_error, r_done, ~w_idle};
      default: w_rmux = '0;
    endcase
  end

  // Handshake: one-cycle ready pulse, rdata valid alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= valid & ~r_ready;
      r_rdata <= w_req_rd ? DATA_W'(w_rmux) : '0;
    end
  end

  assign ready     = r_ready;
  assign rdata     = r_rdata;
  assign acc_run   = w_acc_run;
  assign acc_delay = r_delay;
  assign busy      = ~w_idle;
  assign done      = r_done;

endmodule
